pipe_adder_nb: RTL and testbench
================================

// Module: pipe_adder_nb
// PURPOSE
//  Parametrised, pipelined N-bit add/subtract unit built from SLICE-bit ripple-carry slices.
//  One slice is evaluated per pipeline stage; the carry is registered between stages.
//  Operand slices are skewed in and result slices de-skewed out, giving throughput 1 op/cycle.
//  Serves as the ALU adder datapath and the PC/address adder where a single-cycle RCA misses timing.
// PARAMETERS
//  WIDTH   16  operand/result width; must be a multiple of SLICE
//  SLICE    4  bits per ripple stage; STAGES = WIDTH/SLICE (derived localparam)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  C_in       in   1      carry-in (ignored when sub=1)
//  sub        in   1      1: S = A - B (B inverted, carry-in forced 1)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts the result this cycle
//  S          out  WIDTH  sum/difference
//  C_out      out  1      carry out of the MSB (for sub: 1 means no borrow)
//  Ofl        out  1      signed overflow = carry into MSB XOR carry out of MSB
//  Zero       out  1      S == 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage-valid bits, out_valid, S, C_out, Ofl and Zero clear to 0;
//    skew/de-skew registers clear to 0. in_ready=1 once reset is released.
//  - Advance: adv = !out_valid | out_ready. The whole pipeline (all stages) moves only when adv=1;
//    otherwise every register holds (global stall, no bubble squeezing).
//  - in_ready = adv (combinational). Beat accepted iff in_valid & in_ready.
//  - Stage k (0..STAGES-1) adds A[k*SLICE +: SLICE], B'[k-slice], carry from stage k-1
//    (stage 0 uses sub ? 1 : C_in); B' = sub ? ~B : B, inversion applied at accept.
//  - Latency: a beat accepted at edge t presents out_valid=1 with its result after edge t+STAGES-1,
//    i.e. STAGES register stages, the last stage being the output register.
//  - Output register holds S, C_out, Ofl and Zero stable while out_valid & !out_ready.
//  - Ofl is computed in the final stage from the MSB slice's internal carry; Zero from the
//    assembled S. Both are valid only when out_valid=1 but are registered, never combinational.
//  - Wrap-around: modular WIDTH-bit arithmetic; 0xFFFF+1 = 0x0000 with C_out=1 (WIDTH=16).
//  - Simultaneous accept and drain in one cycle is legal and sustains 1 op/cycle.
//  - Bubbles: a stage whose valid bit is 0 still computes, but its result is never
//    marked valid; out_valid follows the valid bit of the final stage only.
//  - Reset mid-operation: all in-flight beats are dropped; no partial result ever appears.
//  - WIDTH==SLICE: STAGES=1; the unit degenerates to one registered RCA stage.
// STRUCTURE
//  - Shared package adder_pkg: default SLICE constant and the STAGES function
//    (WIDTH/SLICE); an elaboration check that WIDTH % SLICE == 0 also sits there.
//  - Sub-module pipe_adder_slice: combinational SLICE-bit ripple adder (A, B, C_in,
//    S, C_out, plus C_msb = carry into its top bit for overflow detection).
//  - Top level: generate loop of STAGES slices, the per-stage valid chain,
//    the triangular operand-skew and result-deskew register arrays, and the output register.
// TESTING (WIDTH=16, SLICE=4 unless stated)
//  1. Reset, then A=0x1234 B=0x4321 C_in=0 sub=0 -> out_valid 4 cycles later, S=0x5555 C_out=0 Ofl=0 Zero=0.
//  2. A=0xFFFF B=0x0001 sub=0 -> S=0x0000 C_out=1 Zero=1 Ofl=0 (full carry ripple through all stages).
//  3. A=0x8000 B=0x0001 sub=1 -> S=0x7FFF C_out=1 Ofl=1; A=0x0003 B=0x0005 sub=1 -> S=0xFFFE C_out=0.
//  4. 8 back-to-back beats with out_ready held 1 -> 8 results on consecutive cycles, in order.
//     Then out_ready=0 for 3 cycles mid-stream -> in_ready=0, outputs held, nothing lost or duplicated.
//  5. rst_n pulsed low for half a cycle with 3 beats in flight -> out_valid=0 immediately;
//     no stale beat emerges; the next accepted beat takes the full 4-cycle latency.
//  6. Random 10k beats with random in_valid/out_ready, at WIDTH=16/SLICE=4 and WIDTH=8/SLICE=8
//     -> scoreboard matches {C_out,S}=A+B+cin, Ofl and Zero against a behavioural model.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined slice adder.
package adder_pkg;

  localparam int unsigned DEFAULT_SLICE = 4;

  // Number of ripple stages (one register stage per slice).
  function automatic int unsigned adder_stages(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

  // Elaboration-time legality of a WIDTH/SLICE pair.
  function automatic bit slice_divides(input int unsigned width, input int unsigned slice);
    return (slice != 0) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_nb_if.sv
// Operand/result handshake bundle of the pipelined adder.
interface pipe_adder_nb_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             Ofl;
  logic             Zero;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, A, B, C_in, sub, out_ready,
    input  in_ready, out_valid, S, C_out, Ofl, Zero
  );

  // Adder side.
  modport slave (
    input  in_valid, A, B, C_in, sub, out_ready,
    output in_ready, out_valid, S, C_out, Ofl, Zero
  );
endinterface

// File: rtl/pipe_adder_slice.sv
// Combinational SLICE-bit ripple-carry adder; c_msb is the carry into the top bit.
module pipe_adder_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [SLICE:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int unsigned i = 0; i < SLICE; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/pipe_adder_nb.sv
// Pipelined WIDTH-bit add/subtract: one SLICE-bit ripple stage per register stage,
// global stall on output back-pressure, 1 op/cycle throughput.
module pipe_adder_nb
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = DEFAULT_SLICE
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_adder_nb_if.slave    bus
);

  localparam int unsigned STAGES = adder_stages(WIDTH, SLICE);
  localparam int unsigned LAST   = STAGES - 1;

  if (!slice_divides(WIDTH, SLICE)) begin : g_bad_cfg
    $error("pipe_adder_nb: WIDTH must be a non-zero multiple of SLICE");
  end

  // Each stage word x holds finished sum slices at the top and pending A slices at
  // the bottom; it rotates right by SLICE per stage, so after STAGES stages x == S.
  // y carries the pending (already conditioned) B slices the same way.
  logic             adv;
  logic             v_src [STAGES];
  logic [WIDTH-1:0] x_src [STAGES];
  logic [WIDTH-1:0] y_src [STAGES];
  logic             c_src [STAGES];
  logic [SLICE-1:0] sum   [STAGES];
  logic             c_sl  [STAGES];
  logic             c_msb [STAGES];
  logic [WIDTH-1:0] x_nxt [STAGES];
  logic [WIDTH-1:0] y_nxt [STAGES];

  logic             v_q   [STAGES];
  logic [WIDTH-1:0] x_q   [STAGES];
  logic [WIDTH-1:0] y_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ofl_q;
  logic             zero_q;

  // Whole pipeline advances together; no bubble squeezing.
  assign adv          = !v_q[LAST] | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_src[k] = bus.in_valid & adv;
      assign x_src[k] = bus.A;
      assign y_src[k] = bus.sub ? ~bus.B : bus.B;
      assign c_src[k] = bus.sub | bus.C_in;
    end else begin : g_body
      assign v_src[k] = v_q[k-1];
      assign x_src[k] = x_q[k-1];
      assign y_src[k] = y_q[k-1];
      assign c_src[k] = c_q[k-1];
    end

    pipe_adder_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .a     (x_src[k][SLICE-1:0]),
      .b     (y_src[k][SLICE-1:0]),
      .c_in  (c_src[k]),
      .s     (sum[k]),
      .c_out (c_sl[k]),
      .c_msb (c_msb[k])
    );

    assign x_nxt[k] = (x_src[k] >> SLICE) | (WIDTH'(sum[k]) << (WIDTH - SLICE));
    assign y_nxt[k] = y_src[k] >> SLICE;
  end

  // Stage registers; the last stage doubles as the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        x_q[k] <= '0;
        y_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ofl_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= v_src[k];
        x_q[k] <= x_nxt[k];
        y_q[k] <= y_nxt[k];
        c_q[k] <= c_sl[k];
      end
      ofl_q  <= c_msb[LAST] ^ c_sl[LAST];
      zero_q <= (x_nxt[LAST] == '0);
    end
  end

  assign bus.out_valid = v_q[LAST];
  assign bus.S         = x_q[LAST];
  assign bus.C_out     = c_q[LAST];
  assign bus.Ofl       = ofl_q;
  assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_pipe_adder_nb.sv
// Self-checking bench: directed vectors plus randomised traffic against a queue scoreboard.
module tb_pipe_adder_nb;

  localparam int W0 = 16;
  localparam int S0 = 4;
  localparam int W1 = 8;
  localparam int S1 = 8;
  localparam int N_RAND = 10000;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic prev_hold[2] = '{1'b0, 1'b0};
  exp_t prev_out[2];

  pipe_adder_nb_if #(.WIDTH(W0)) bus0 ();
  pipe_adder_nb_if #(.WIDTH(W1)) bus1 ();

  pipe_adder_nb #(.WIDTH(W0), .SLICE(S0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pipe_adder_nb #(.WIDTH(W1), .SLICE(S1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Plain modular arithmetic; overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sb);
    logic [16:0] mask, aa, bb, full;
    exp_t e;
    mask = (17'd1 << w) - 17'd1;
    aa   = {1'b0, a} & mask;
    bb   = (sb ? {1'b0, ~b} : {1'b0, b}) & mask;
    full = aa + bb + 17'(sb ? 1'b1 : cin);
    e.s  = 16'(full & mask);
    e.c  = full[w];
    e.o  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    e.z  = ((full & mask) == 17'd0);
    return e;
  endfunction

  function automatic int qsize(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  // Per-cycle compare: handshake rule, output hold, in-order results.
  task automatic score(input int idx, input logic ov, input logic ordy, input logic iv,
                       input logic ird, input exp_t got, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic sb);
    exp_t e;
    int   w;
    w = (idx == 0) ? W0 : W1;
    check($sformatf("in_ready[%0d]", idx), 32'(ird), 32'(!ov || ordy));
    if (prev_hold[idx]) begin
      check($sformatf("hold_valid[%0d]", idx), 32'(ov), 32'd1);
      check($sformatf("hold_data[%0d]", idx), 32'(got), 32'(prev_out[idx]));
    end
    if (ov && ordy) begin
      if (qsize(idx) == 0) begin
        fail_now($sformatf("spurious_result[%0d] got 0x%0h", idx, got));
      end else begin
        if (idx == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        check($sformatf("result[%0d]", idx), 32'(got), 32'(e));
      end
    end
    if (iv && ird) begin
      if (idx == 0) q0.push_back(model(w, a, b, cin, sb));
      else          q1.push_back(model(w, a, b, cin, sb));
    end
    prev_hold[idx] = ov && !ordy;
    prev_out[idx]  = got;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      score(0, bus0.out_valid, bus0.out_ready, bus0.in_valid, bus0.in_ready,
            {16'(bus0.S), bus0.C_out, bus0.Ofl, bus0.Zero},
            bus0.A, bus0.B, bus0.C_in, bus0.sub);
      score(1, bus1.out_valid, bus1.out_ready, bus1.in_valid, bus1.in_ready,
            {16'(bus1.S), bus1.C_out, bus1.Ofl, bus1.Zero},
            16'(bus1.A), 16'(bus1.B), bus1.C_in, bus1.sub);
    end
  end

  // Reset drops every in-flight beat.
  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
    prev_hold[0] = 1'b0;
    prev_hold[1] = 1'b0;
  end

  task automatic set_iv(input int idx, input logic v);
    if (idx == 0) bus0.in_valid = v;
    else          bus1.in_valid = v;
  endtask

  task automatic set_ordy(input int idx, input logic v);
    if (idx == 0) bus0.out_ready = v;
    else          bus1.out_ready = v;
  endtask

  // Present one beat and hold it until accepted; returns at posedge+1.
  task automatic send(input int idx, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sb);
    bit ok;
    ok = 1'b0;
    if (idx == 0) begin
      bus0.A = a; bus0.B = b; bus0.C_in = cin; bus0.sub = sb; bus0.in_valid = 1'b1;
    end else begin
      bus1.A = 8'(a); bus1.B = 8'(b); bus1.C_in = cin; bus1.sub = sb; bus1.in_valid = 1'b1;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (((idx == 0) ? bus0.in_ready : bus1.in_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now($sformatf("send_timeout[%0d]", idx));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int idx, input string nm);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (qsize(idx) == 0) break;
    end
    @(posedge clk);
    #1;
    check(nm, 32'(qsize(idx)), 32'd0);
  endtask

  // Single beat on the 16-bit unit with literal expectations and latency.
  task automatic directed(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sb, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez);
    int lat;
    bit got;
    check({nm, "_model"}, 32'(model(W0, a, b, cin, sb)), 32'({es, ec, eo, ez}));
    bus0.out_ready = 1'b1;
    send(0, a, b, cin, sb);
    bus0.in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    check({nm, "_seen"}, 32'(got), 32'd1);
    check({nm, "_latency"}, 32'(lat), 32'd4);
    check({nm, "_S"}, 32'(bus0.S), 32'(es));
    check({nm, "_C_out"}, 32'(bus0.C_out), 32'(ec));
    check({nm, "_Ofl"}, 32'(bus0.Ofl), 32'(eo));
    check({nm, "_Zero"}, 32'(bus0.Zero), 32'(ez));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_op(input int w);
    logic [15:0] top;
    top = 16'd1 << (w - 1);
    case ($urandom_range(7))
      0:       return 16'd0;
      1:       return (top << 1) - 16'd1;
      2:       return top;
      3:       return top - 16'd1;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_run(input int idx, input int n);
    int w;
    w = (idx == 0) ? W0 : W1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < 30) begin
        set_iv(idx, 1'b0);
        @(posedge clk);
        #1;
      end
      send(idx, rand_op(w), rand_op(w), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    set_iv(idx, 1'b0);
  endtask

  task automatic rand_session(input int idx);
    bit done;
    done = 1'b0;
    fork
      begin
        rand_run(idx, N_RAND);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          set_ordy(idx, $urandom_range(99) < 70);
        end
      end
    join
    set_ordy(idx, 1'b1);
    drain(idx, $sformatf("rand_drain[%0d]", idx));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int run, cnt;
    bit seen;
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.A = '0; bus0.B = '0; bus0.C_in = 1'b0; bus0.sub = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.A = '0; bus1.B = '0; bus1.C_in = 1'b0; bus1.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_S", 32'(bus0.S), 32'd0);
    check("rst_C_out", 32'(bus0.C_out), 32'd0);
    check("rst_Ofl", 32'(bus0.Ofl), 32'd0);
    check("rst_Zero", 32'(bus0.Zero), 32'd0);
    check("rst_out_valid_w8", 32'(bus1.out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    @(posedge clk);
    #1;

    directed("t1_add",        16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    directed("t2_wrap",       16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("t3_sub_ofl",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    directed("t3_sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("cin_ignored",   16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("cin_add_ofl",   16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

    // Back-to-back stream: results on consecutive cycles.
    bus0.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(0, 16'(i * 16'h1111), 16'(16'hF00F - i), 1'(i % 2), 1'b0);
        set_iv(0, 1'b0);
      end
      begin
        seen = 1'b0;
        run  = 0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (bus0.out_valid === 1'b1) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) run = 1;
        for (int i = 0; i < 7; i++) begin
          @(negedge clk);
          if (bus0.out_valid === 1'b1) run++;
        end
        check("t4_consecutive", 32'(run), 32'd8);
      end
    join
    drain(0, "t4_drain_a");

    // Mid-stream back-pressure.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(0, 16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
        set_iv(0, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus0.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("t4_stall_in_ready", 32'(bus0.in_ready), 32'd0);
          check("t4_stall_out_valid", 32'(bus0.out_valid), 32'd1);
          @(posedge clk);
        end
        #1 bus0.out_ready = 1'b1;
      end
    join
    drain(0, "t4_drain_b");

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send(0, 16'h0F0F, 16'(i + 1), 1'b0, 1'b0);
    set_iv(0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("t5_rst_S", 32'(bus0.S), 32'd0);
    #4 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus0.out_valid !== 1'b0) cnt++;
    end
    check("t5_no_stale", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    directed("t5_after_reset", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Random traffic on both configurations at once.
    fork
      rand_session(0);
      rand_session(1);
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
